// File: rtl/jstk_spi_poller_pkg.sv
// Shared constants, FSM state type and frame pack/unpack helpers for the PmodJSTK poller.
package jstk_pkg;

   localparam int unsigned JSTK_NBYTES  = 5;
   localparam logic [5:0]  JSTK_CMD_LED = 6'b100000;

   // Position of each field inside the 5-byte response frame
   localparam int unsigned JSTK_B_XLO = 0;
   localparam int unsigned JSTK_B_XHI = 1;
   localparam int unsigned JSTK_B_YLO = 2;
   localparam int unsigned JSTK_B_YHI = 3;
   localparam int unsigned JSTK_B_BTN = 4;

   typedef enum logic [2:0] {
      StIdle,
      StCsSetup,
      StShift,
      StByteGap,
      StDone,
      StChGap
   } jstk_state_e;

   function automatic logic [9:0] jstk_unpack_pos(logic [7:0] lo, logic [7:0] hi);
      return {hi[1:0], lo};
   endfunction

   function automatic logic [2:0] jstk_unpack_btn(logic [7:0] b);
      return b[2:0];
   endfunction

   function automatic logic [7:0] jstk_pack_cmd(logic [1:0] led);
      return {JSTK_CMD_LED, led};
   endfunction

endpackage

// File: rtl/jstk_spi_poller_if.sv
// Shared SPI bus to the joysticks: one chip select per device, common SCLK/MOSI/MISO.
interface jstk_spi_poller_if #(
   parameter int unsigned N_CH = 2
);
   logic [N_CH-1:0] cs_n;
   logic            SCLK;
   logic            MOSI;
   logic            MISO;

   modport master (output cs_n, output SCLK, output MOSI, input MISO);
   modport slave  (input cs_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_byte_xfer.sv
// Mode-0 single-byte SPI shifter: SCLK low then high per bit, MOSI MSB first, MISO taken on rise.
module spi_byte_xfer #(
   parameter int unsigned SCLK_DIV = 66
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       MISO,
   output logic       SCLK,
   output logic       MOSI,
   output logic [7:0] rx_byte,
   output logic       done
);

   localparam int unsigned DivW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

   logic            active_q, active_d;
   logic [2:0]      bit_q, bit_d;
   logic [DivW-1:0] div_q, div_d;
   logic            sclk_q, sclk_d;
   logic            mosi_q, mosi_d;
   logic [7:0]      tx_q, tx_d;
   logic [7:0]      rx_q, rx_d;
   logic            phase_end;

   assign phase_end = (div_q == DivW'(SCLK_DIV - 1));

   always_comb begin
      active_d = active_q;
      bit_d    = bit_q;
      div_d    = div_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      if (!active_q) begin
         if (start) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            mosi_d   = tx_byte[7];
            tx_d     = {tx_byte[6:0], 1'b0};
            bit_d    = 3'd7;
            div_d    = '0;
         end
      end else if (!phase_end) begin
         div_d = div_q + 1'b1;
      end else begin
         div_d = '0;
         if (!sclk_q) begin
            // Capture on the edge that raises SCLK: MISO has been stable through the low phase
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], MISO};
         end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd0) begin
               active_d = 1'b0;
               mosi_d   = 1'b0;
            end else begin
               bit_d  = bit_q - 1'b1;
               mosi_d = tx_q[7];
               tx_d   = {tx_q[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         active_q <= 1'b0;
         bit_q    <= '0;
         div_q    <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         tx_q     <= '0;
         rx_q     <= '0;
      end else begin
         active_q <= active_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
      end
   end

   // High on the final cycle of the byte; rx_byte is complete at that point
   assign done    = active_q && sclk_q && phase_end && (bit_q == 3'd0);
   assign SCLK    = sclk_q;
   assign MOSI    = mosi_q;
   assign rx_byte = rx_q;

endmodule

// File: rtl/jstk_spi_poller.sv
// Polls N_CH PmodJSTK joysticks over a shared SPI bus on every poll tick and registers
// the decoded X/Y/button state per channel.
module jstk_spi_poller
   import jstk_pkg::*;
#(
   parameter int unsigned N_CH         = 2,
   parameter int unsigned SCLK_DIV     = 66,
   parameter int unsigned POLL_DIV     = 20_000_000,
   parameter int unsigned CS_SETUP_CYC = 1500,
   parameter int unsigned BYTE_GAP_CYC = 1000,
   localparam int unsigned ChW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 poll_en,
   input  logic [2*N_CH-1:0]    led_cmd,
   jstk_spi_poller_if.master    spi,
   output logic [10*N_CH-1:0]   pos_x,
   output logic [10*N_CH-1:0]   pos_y,
   output logic [3*N_CH-1:0]    btn,
   output logic                 upd_valid,
   output logic [ChW-1:0]       upd_ch,
   output logic                 busy,
   output logic                 overrun
);

   localparam int unsigned PollW  = $clog2(POLL_DIV);
   localparam int unsigned TmrMax = (CS_SETUP_CYC > BYTE_GAP_CYC) ? CS_SETUP_CYC : BYTE_GAP_CYC;
   localparam int unsigned TmrW   = $clog2(TmrMax + 1);

   jstk_state_e       state_q, state_d;
   logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
   logic [TmrW-1:0]   tmr_q, tmr_d;
   logic [ChW-1:0]    ch_q, ch_d, ch_nxt;
   logic [2:0]        byte_q, byte_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [N_CH-1:0]   cs_n_q, cs_n_d;
   logic              busy_q, busy_d;
   logic              overrun_q, overrun_d;
   logic              upd_valid_q, upd_valid_d;
   logic [ChW-1:0]    upd_ch_q, upd_ch_d;
   logic [7:0]        rx_q [JSTK_NBYTES-1];
   logic [7:0]        rx_d [JSTK_NBYTES-1];
   logic [9:0]        pos_x_q [N_CH];
   logic [9:0]        pos_x_d [N_CH];
   logic [9:0]        pos_y_q [N_CH];
   logic [9:0]        pos_y_d [N_CH];
   logic [2:0]        btn_q [N_CH];
   logic [2:0]        btn_d [N_CH];

   logic              tick;
   logic              xfer_start;
   logic              xfer_done;
   logic [7:0]        xfer_tx;
   logic [7:0]        xfer_rx;
   logic              sclk;
   logic              mosi;

   function automatic logic [N_CH-1:0] cs_sel(logic [ChW-1:0] c);
      return ~(N_CH'(1) << c);
   endfunction

   assign tick    = (poll_cnt_q == PollW'(POLL_DIV - 1));
   assign ch_nxt  = ch_q + 1'b1;
   // Only the first byte of a frame carries the LED command
   assign xfer_tx = (state_q == StCsSetup) ? cmd_q : 8'h00;

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      ch_d        = ch_q;
      byte_d      = byte_q;
      cmd_d       = cmd_q;
      cs_n_d      = cs_n_q;
      busy_d      = busy_q;
      overrun_d   = overrun_q;
      upd_valid_d = 1'b0;
      upd_ch_d    = upd_ch_q;
      rx_d        = rx_q;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      btn_d       = btn_q;
      xfer_start  = 1'b0;
      poll_cnt_d  = tick ? '0 : poll_cnt_q + 1'b1;

      if (tick && busy_q) overrun_d = 1'b1;

      case (state_q)
         StIdle: begin
            if (tick && poll_en) begin
               state_d = StCsSetup;
               ch_d    = '0;
               tmr_d   = '0;
               busy_d  = 1'b1;
               cs_n_d  = cs_sel('0);
               cmd_d   = jstk_pack_cmd(led_cmd[1:0]);
            end
         end
         StCsSetup: begin
            if (tmr_q == TmrW'(CS_SETUP_CYC - 1)) begin
               xfer_start = 1'b1;
               byte_d     = '0;
               state_d    = StShift;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         StShift: begin
            if (xfer_done) begin
               if (byte_q == 3'(JSTK_NBYTES - 1)) begin
                  // Release the device and publish the whole frame in the same edge
                  state_d          = StDone;
                  cs_n_d           = '1;
                  pos_x_d[ch_q]    = jstk_unpack_pos(rx_q[JSTK_B_XLO], rx_q[JSTK_B_XHI]);
                  pos_y_d[ch_q]    = jstk_unpack_pos(rx_q[JSTK_B_YLO], rx_q[JSTK_B_YHI]);
                  btn_d[ch_q]      = jstk_unpack_btn(xfer_rx);
                  upd_valid_d      = 1'b1;
                  upd_ch_d         = ch_q;
               end else begin
                  rx_d[byte_q[1:0]] = xfer_rx;
                  state_d           = StByteGap;
                  tmr_d             = '0;
               end
            end
         end
         StByteGap: begin
            if (tmr_q == TmrW'(BYTE_GAP_CYC - 1)) begin
               xfer_start = 1'b1;
               byte_d     = byte_q + 1'b1;
               state_d    = StShift;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StChGap;
            tmr_d   = '0;
         end
         StChGap: begin
            if (tmr_q == TmrW'(BYTE_GAP_CYC - 1)) begin
               if (ch_q == ChW'(N_CH - 1)) begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
               end else begin
                  state_d = StCsSetup;
                  ch_d    = ch_nxt;
                  tmr_d   = '0;
                  cs_n_d  = cs_sel(ch_nxt);
                  cmd_d   = jstk_pack_cmd(led_cmd[2*ch_nxt +: 2]);
               end
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         poll_cnt_q  <= '0;
         tmr_q       <= '0;
         ch_q        <= '0;
         byte_q      <= '0;
         cmd_q       <= '0;
         cs_n_q      <= '1;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         upd_valid_q <= 1'b0;
         upd_ch_q    <= '0;
         rx_q        <= '{default: '0};
         pos_x_q     <= '{default: '0};
         pos_y_q     <= '{default: '0};
         btn_q       <= '{default: '0};
      end else begin
         state_q     <= state_d;
         poll_cnt_q  <= poll_cnt_d;
         tmr_q       <= tmr_d;
         ch_q        <= ch_d;
         byte_q      <= byte_d;
         cmd_q       <= cmd_d;
         cs_n_q      <= cs_n_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         upd_valid_q <= upd_valid_d;
         upd_ch_q    <= upd_ch_d;
         rx_q        <= rx_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         btn_q       <= btn_d;
      end
   end

   spi_byte_xfer #(
      .SCLK_DIV (SCLK_DIV)
   ) u_xfer (
      .CLK     (CLK),
      .RST     (RST),
      .start   (xfer_start),
      .tx_byte (xfer_tx),
      .MISO    (spi.MISO),
      .SCLK    (sclk),
      .MOSI    (mosi),
      .rx_byte (xfer_rx),
      .done    (xfer_done)
   );

   assign spi.cs_n = cs_n_q;
   assign spi.SCLK = sclk;
   assign spi.MOSI = mosi;

   for (genvar k = 0; k < N_CH; k++) begin : g_out
      assign pos_x[10*k +: 10] = pos_x_q[k];
      assign pos_y[10*k +: 10] = pos_y_q[k];
      assign btn[3*k +: 3]     = btn_q[k];
   end

   assign upd_valid = upd_valid_q;
   assign upd_ch    = upd_ch_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_jstk_spi_poller.sv
// Bench for jstk_spi_poller: per-channel joystick slave model on the bus, bus monitor, and
// scenario tasks comparing outputs against frame-decoding rules computed here.
module tb_jstk_spi_poller;

   localparam int unsigned N_CH         = 2;
   localparam int unsigned SCLK_DIV     = 2;
   localparam int unsigned CS_SETUP_CYC = 4;
   localparam int unsigned BYTE_GAP_CYC = 3;
   localparam int unsigned POLL_DIV     = 2000;
   localparam int unsigned POLL_DIV_B   = 300;
   localparam int unsigned CS_LOW_LEN   = CS_SETUP_CYC + 80 * SCLK_DIV + 4 * BYTE_GAP_CYC;
   localparam int          LIMIT        = 5000;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RST, poll_en;
   logic [3:0]  led_cmd;
   logic [19:0] pos_x, pos_y;
   logic [5:0]  btn;
   logic        upd_valid, busy, overrun;
   logic [0:0]  upd_ch;

   logic        rst_b, poll_en_b;
   logic [19:0] pos_x_b, pos_y_b;
   logic [5:0]  btn_b;
   logic        upd_valid_b, busy_b, overrun_b;
   logic [0:0]  upd_ch_b;

   jstk_spi_poller_if #(.N_CH(N_CH)) spi ();
   jstk_spi_poller_if #(.N_CH(N_CH)) spi_b ();

   jstk_spi_poller #(
      .N_CH(N_CH), .SCLK_DIV(SCLK_DIV), .POLL_DIV(POLL_DIV),
      .CS_SETUP_CYC(CS_SETUP_CYC), .BYTE_GAP_CYC(BYTE_GAP_CYC)
   ) dut (
      .CLK(CLK), .RST(RST), .poll_en(poll_en), .led_cmd(led_cmd), .spi(spi),
      .pos_x(pos_x), .pos_y(pos_y), .btn(btn), .upd_valid(upd_valid), .upd_ch(upd_ch),
      .busy(busy), .overrun(overrun)
   );

   // Second instance with a poll period shorter than a sweep
   jstk_spi_poller #(
      .N_CH(N_CH), .SCLK_DIV(SCLK_DIV), .POLL_DIV(POLL_DIV_B),
      .CS_SETUP_CYC(CS_SETUP_CYC), .BYTE_GAP_CYC(BYTE_GAP_CYC)
   ) dut_b (
      .CLK(CLK), .RST(rst_b), .poll_en(poll_en_b), .led_cmd(4'b0000), .spi(spi_b),
      .pos_x(pos_x_b), .pos_y(pos_y_b), .btn(btn_b), .upd_valid(upd_valid_b),
      .upd_ch(upd_ch_b), .busy(busy_b), .overrun(overrun_b)
   );
   assign spi_b.MISO = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] resp [2][5];
   logic       glitch_en = 1'b0;

   // Bus monitor and joystick slave model, evaluated away from the active edge
   logic [1:0] cs_prev = 2'b11;
   logic       sclk_prev = 1'b0;
   logic       mosi_prev = 1'b0;
   int         rise_n = 0, fall_n = 0, cs_fall_cnt = 0;
   int         cs0_cnt = 0, cs0_len = 0;
   int         mon_unstable = 0, mon_multi = 0, mon_sclk_bad = 0, upd_b_cnt = 0;
   int         upd_log[$];
   logic [7:0] mosi_cap [2][5];

   always @(negedge CLK) begin
      int act;
      int b;
      act = -1;
      if (spi.cs_n == 2'b10) act = 0;
      if (spi.cs_n == 2'b01) act = 1;
      if (spi.cs_n != cs_prev) begin
         rise_n = 0;
         fall_n = 0;
         if ((cs_prev & ~spi.cs_n) != 2'b00) cs_fall_cnt++;
      end
      if (spi.SCLK && !sclk_prev) begin
         if (spi.MOSI !== mosi_prev) mon_unstable++;
         if (act >= 0 && rise_n < 40) mosi_cap[act][rise_n / 8][7 - (rise_n % 8)] = spi.MOSI;
         rise_n++;
      end
      if (!spi.SCLK && sclk_prev) fall_n++;
      if (spi.SCLK && act < 0) mon_sclk_bad++;
      if (spi.cs_n == 2'b00) mon_multi++;
      if (!spi.cs_n[0]) cs0_cnt++;
      else if (!cs_prev[0]) begin
         cs0_len = cs0_cnt;
         cs0_cnt = 0;
      end
      if (upd_valid) upd_log.push_back(int'(upd_ch));
      if (upd_valid_b) upd_b_cnt++;
      if (act >= 0 && (!spi.SCLK || !glitch_en)) begin
         b = fall_n / 8;
         spi.MISO = (b < 5) ? resp[act][b][7 - (fall_n % 8)] : 1'b0;
      end else begin
         spi.MISO = glitch_en ? 1'($urandom) : 1'b0;
      end
      cs_prev   = spi.cs_n;
      sclk_prev = spi.SCLK;
      mosi_prev = spi.MOSI;
   end

   function automatic logic [9:0] model_pos(logic [7:0] lo, logic [7:0] hi);
      return 10'((int'(hi) % 4) * 256 + int'(lo));
   endfunction

   // Waits for the next complete sweep; returns the upd_log index where it began
   task automatic wait_sweep(input string tag, output int u_start);
      int n = 0;
      while (busy && n < LIMIT) begin @(negedge CLK); n++; end
      while (!busy && n < LIMIT) begin @(negedge CLK); n++; end
      u_start = upd_log.size();
      while (busy && n < LIMIT) begin @(negedge CLK); n++; end
      n_tests++;
      if (n >= LIMIT) begin
         n_fail++;
         $display("FAIL %s_timeout: waited %0d cycles, limit %0d", tag, n, LIMIT);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      n_tests++;
      if (spi.cs_n !== 2'b11 || spi.SCLK !== 1'b0 || spi.MOSI !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_bus: cs_n=%b sclk=%b mosi=%b, want 11 0 0", spi.cs_n, spi.SCLK,
                  spi.MOSI);
      end
      n_tests++;
      if (pos_x !== 20'd0 || pos_y !== 20'd0 || btn !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: x=%h y=%h btn=%b, want zeros", pos_x, pos_y, btn);
      end
      n_tests++;
      if (busy !== 1'b0 || overrun !== 1'b0 || upd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: busy=%b overrun=%b upd=%b, want 0 0 0", busy, overrun,
                  upd_valid);
      end
      RST = 1'b0;
   endtask

   task automatic test_single_read();
      int u0;
      resp[0] = '{8'hA5, 8'h02, 8'h3C, 8'h01, 8'h05};
      resp[1] = '{8'hFF, 8'h03, 8'h00, 8'h00, 8'h02};
      led_cmd = 4'b0010;
      wait_sweep("single", u0);
      n_tests++;
      if (pos_x[9:0] !== model_pos(resp[0][0], resp[0][1]) || pos_x[9:0] !== 10'h2A5) begin
         n_fail++;
         $display("FAIL single_pos_x: got %h want %h", pos_x[9:0], 10'h2A5);
      end
      n_tests++;
      if (pos_y[9:0] !== model_pos(resp[0][2], resp[0][3]) || pos_y[9:0] !== 10'h13C) begin
         n_fail++;
         $display("FAIL single_pos_y: got %h want %h", pos_y[9:0], 10'h13C);
      end
      n_tests++;
      if (btn[2:0] !== 3'b101) begin
         n_fail++;
         $display("FAIL single_btn: got %b want 101", btn[2:0]);
      end
      for (int b = 0; b < 5; b++) begin
         n_tests++;
         if (mosi_cap[0][b] !== ((b == 0) ? 8'h82 : 8'h00)) begin
            n_fail++;
            $display("FAIL single_mosi_byte%0d: got %h want %h", b, mosi_cap[0][b],
                     (b == 0) ? 8'h82 : 8'h00);
         end
      end
      n_tests++;
      if (cs0_len != CS_LOW_LEN) begin
         n_fail++;
         $display("FAIL single_cs_len: got %0d want %0d", cs0_len, CS_LOW_LEN);
      end
      n_tests++;
      if (upd_log.size() < u0 + 1 || upd_log[u0] != 0) begin
         n_fail++;
         $display("FAIL single_upd_ch0: log size %0d from %0d, want first entry 0",
                  upd_log.size(), u0);
      end
   endtask

   task automatic test_sweep_order();
      int u0;
      wait_sweep("order", u0);
      n_tests++;
      if (upd_log.size() != u0 + 2 || upd_log[u0] != 0 || upd_log[u0 + 1] != 1) begin
         n_fail++;
         $display("FAIL order_upd: %0d pulses, want exactly ch0 then ch1", upd_log.size() - u0);
      end
      n_tests++;
      if (pos_x[19:10] !== 10'h3FF || btn[5:3] !== 3'b010) begin
         n_fail++;
         $display("FAIL order_ch1: x=%h btn=%b want 3ff 010", pos_x[19:10], btn[5:3]);
      end
      n_tests++;
      if (pos_y[19:10] !== model_pos(resp[1][2], resp[1][3])) begin
         n_fail++;
         $display("FAIL order_ch1_y: got %h want %h", pos_y[19:10],
                  model_pos(resp[1][2], resp[1][3]));
      end
      n_tests++;
      if (mon_multi != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL order_bus: cs_n==00 seen %0d times, busy=%b; want 0 0", mon_multi, busy);
      end
   endtask

   task automatic test_spi_timing();
      int u0;
      glitch_en = 1'b1;
      resp[0] = '{8'h5A, 8'h01, 8'hC3, 8'h02, 8'h06};
      resp[1] = '{8'h0F, 8'h02, 8'hF0, 8'h03, 8'h01};
      wait_sweep("timing", u0);
      for (int c = 0; c < 2; c++) begin
         n_tests++;
         if (pos_x[10*c +: 10] !== model_pos(resp[c][0], resp[c][1]) ||
             pos_y[10*c +: 10] !== model_pos(resp[c][2], resp[c][3]) ||
             btn[3*c +: 3] !== resp[c][4][2:0]) begin
            n_fail++;
            $display("FAIL timing_glitch_ch%0d: x=%h y=%h btn=%b", c, pos_x[10*c +: 10],
                     pos_y[10*c +: 10], btn[3*c +: 3]);
         end
      end
      n_tests++;
      if (mon_unstable != 0 || mon_sclk_bad != 0) begin
         n_fail++;
         $display("FAIL timing_bus: mosi changes at rise=%0d, sclk high idle=%0d, want 0 0",
                  mon_unstable, mon_sclk_bad);
      end
   endtask

   task automatic test_random();
      int u0;
      for (int it = 0; it < 3; it++) begin
         for (int c = 0; c < 2; c++)
            for (int b = 0; b < 5; b++) resp[c][b] = 8'($urandom);
         led_cmd = 4'($urandom);
         wait_sweep("random", u0);
         for (int c = 0; c < 2; c++) begin
            n_tests++;
            if (pos_x[10*c +: 10] !== model_pos(resp[c][0], resp[c][1]) ||
                pos_y[10*c +: 10] !== model_pos(resp[c][2], resp[c][3]) ||
                btn[3*c +: 3] !== 3'(int'(resp[c][4]) % 8)) begin
               n_fail++;
               $display("FAIL random%0d_ch%0d: x=%h y=%h btn=%b want %h %h %b", it, c,
                        pos_x[10*c +: 10], pos_y[10*c +: 10], btn[3*c +: 3],
                        model_pos(resp[c][0], resp[c][1]), model_pos(resp[c][2], resp[c][3]),
                        resp[c][4][2:0]);
            end
            n_tests++;
            if (mosi_cap[c][0] !== 8'(128 + ((led_cmd >> (2 * c)) & 4'd3))) begin
               n_fail++;
               $display("FAIL random%0d_cmd_ch%0d: got %h want %h", it, c, mosi_cap[c][0],
                        8'(128 + ((led_cmd >> (2 * c)) & 4'd3)));
            end
         end
      end
      glitch_en = 1'b0;
   endtask

   task automatic test_poll_en_off();
      int n = 0;
      int u0, f0;
      while (busy && n < LIMIT) begin @(negedge CLK); n++; end
      while (!busy && n < LIMIT) begin @(negedge CLK); n++; end
      u0 = upd_log.size();
      repeat (50) @(negedge CLK);
      poll_en = 1'b0;
      while (busy && n < LIMIT) begin @(negedge CLK); n++; end
      n_tests++;
      if (n >= LIMIT || upd_log.size() != u0 + 2) begin
         n_fail++;
         $display("FAIL pollen_finish: %0d updates after %0d cycles, want 2", upd_log.size() - u0,
                  n);
      end
      f0 = cs_fall_cnt;
      repeat (POLL_DIV + 100) @(negedge CLK);
      n_tests++;
      if (cs_fall_cnt != f0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL pollen_quiet: %0d cs_n falls, busy=%b; want 0 0", cs_fall_cnt - f0, busy);
      end
      n_tests++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL pollen_overrun: got %b want 0", overrun);
      end
      poll_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int u0;
      while (spi.cs_n[1] !== 1'b0 && n < 3 * LIMIT) begin @(negedge CLK); n++; end
      repeat (10) @(negedge CLK);
      u0 = upd_log.size();
      RST = 1'b1;
      @(negedge CLK);
      n_tests++;
      if (spi.cs_n !== 2'b11 || spi.SCLK !== 1'b0 || spi.MOSI !== 1'b0 || upd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_bus: cs_n=%b sclk=%b mosi=%b upd=%b, want 11 0 0 0", spi.cs_n,
                  spi.SCLK, spi.MOSI, upd_valid);
      end
      n_tests++;
      if (pos_x !== 20'd0 || pos_y !== 20'd0 || btn !== 6'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: x=%h y=%h btn=%b busy=%b, want zeros", pos_x, pos_y,
                  btn, busy);
      end
      RST = 1'b0;
      n = 0;
      while (!busy && n < 3000) begin @(negedge CLK); n++; end
      n_tests++;
      if (n != POLL_DIV) begin
         n_fail++;
         $display("FAIL rstmid_restart: sweep began %0d cycles after reset, want %0d", n,
                  POLL_DIV);
      end
      n_tests++;
      if (upd_log.size() != u0) begin
         n_fail++;
         $display("FAIL rstmid_no_update: %0d pulses since abort, want 0", upd_log.size() - u0);
      end
   endtask

   task automatic test_overrun();
      int n = 0;
      int u0;
      rst_b = 1'b0;
      while (!busy_b && n < 2 * POLL_DIV_B) begin @(negedge CLK); n++; end
      u0 = upd_b_cnt;
      n_tests++;
      if (n >= 2 * POLL_DIV_B || overrun_b !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_first_tick: overrun=%b after %0d cycles, want 0", overrun_b, n);
      end
      repeat (POLL_DIV_B + 20) @(negedge CLK);
      n_tests++;
      if (overrun_b !== 1'b1 || busy_b !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_set: overrun=%b busy=%b want 1 1", overrun_b, busy_b);
      end
      n = 0;
      while (busy_b && n < LIMIT) begin @(negedge CLK); n++; end
      n_tests++;
      if (n >= LIMIT || upd_b_cnt != u0 + 2) begin
         n_fail++;
         $display("FAIL overrun_sweep_done: %0d updates, want 2", upd_b_cnt - u0);
      end
      repeat (700) @(negedge CLK);
      n_tests++;
      if (overrun_b !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_sticky: got %b want 1", overrun_b);
      end
      rst_b = 1'b1;
      @(negedge CLK);
      n_tests++;
      if (overrun_b !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clear: got %b want 0", overrun_b);
      end
   endtask

   initial begin
      RST       = 1'b1;
      poll_en   = 1'b1;
      led_cmd   = 4'b0000;
      rst_b     = 1'b1;
      poll_en_b = 1'b1;
      spi.MISO  = 1'b0;
      for (int c = 0; c < 2; c++)
         for (int b = 0; b < 5; b++) resp[c][b] = 8'h00;
      test_reset();
      test_single_read();
      test_sweep_order();
      test_spi_timing();
      test_random();
      test_poll_en_off();
      test_reset_mid();
      test_overrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jstk_spi_poller.md
Name: jstk_spi_poller

Overview:
- Parametrised SPI mode-0 master that polls N_CH PmodJSTK joysticks over a shared SCLK/MOSI/MISO bus, with one active-low chip select per joystick.
- On each poll tick it sweeps channels 0..N_CH-1 in order. Each transaction is 5 bytes and carries that channel's LED command.
- Decoded 10-bit X/Y and button state are registered per channel, with an update strobe.
- Replaces the single-joystick interface plus fixed 5 Hz divider; feeds display/LED/game logic.

Parameters:
- N_CH, 2, number of joysticks (1..8).
- SCLK_DIV, 66, CLK cycles per SCLK half-period (≥2; 66 gives ~758 kHz at 100 MHz).
- POLL_DIV, 20_000_000, CLK cycles between poll ticks (5 Hz at 100 MHz; ≥ one full sweep).
- CS_SETUP_CYC, 1500, cycles from cs_n fall to first SCLK rise (15 us).
- BYTE_GAP_CYC, 1000, idle cycles between bytes and between channels (10 us).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- poll_en  in  1  enables new sweeps; low lets the current sweep finish.
- led_cmd  in  2*N_CH  per-channel LED bits; ch k = [2k+1:2k].
- MISO  in  1  shared serial data from joysticks.
- cs_n  out  N_CH  chip selects, active low, one-hot-low while active.
- SCLK  out  1  serial clock, idle low.
- MOSI  out  1  serial data, MSB first.
- pos_x  out  10*N_CH  X position; ch k = [10k+9:10k].
- pos_y  out  10*N_CH  Y position, same packing.
- btn  out  3*N_CH  {trigger, btn1, btn0} per channel.
- upd_valid  out  1  one-cycle pulse when a channel's outputs change.
- upd_ch  out  clog2(N_CH) (min 1)  channel just updated; valid with upd_valid.
- busy  out  1  high from sweep start to end of last channel.
- overrun  out  1  sticky: a tick arrived while busy; cleared only by RST.

Behaviour:
- Reset (takes effect on the clocked edge, also mid-transfer):
  - cs_n all 1; SCLK, MOSI, upd_valid, busy, overrun 0; pos_x/pos_y/btn 0.
  - Poll counter 0; FSM to IDLE.
  - An aborted transaction updates nothing.
- Poll timer:
  - Free-running counter 0..POLL_DIV-1; tick on terminal count, regardless of poll_en.
  - Tick with poll_en=1 and FSM IDLE: sweep starts next cycle at channel 0.
  - Tick while busy: dropped, overrun←1.
  - Tick with poll_en=0: ignored, no overrun.
- FSM states: IDLE → CS_SETUP → SHIFT → (BYTE_GAP → SHIFT)×4 → DONE → CH_GAP → CS_SETUP (next ch) | IDLE.
  - CS_SETUP: cs_n[ch]=0 for CS_SETUP_CYC cycles. led_cmd[ch] is latched on entry into cmd={6'b100000, led[1:0]}.
  - SHIFT: 8 bits, each SCLK low SCLK_DIV cycles then high SCLK_DIV cycles.
    - MOSI updates at the start of the low phase.
    - MISO is sampled on the cycle SCLK rises.
    - SCLK ends low after bit 0.
  - Bytes sent: cmd, 0x00, 0x00, 0x00, 0x00.
  - BYTE_GAP: SCLK low, MOSI 0, cs_n held low, BYTE_GAP_CYC cycles.
  - DONE (1 cycle): cs_n[ch]←1 and registers for ch loaded atomically:
    - X = {rx1[1:0], rx0}
    - Y = {rx3[1:0], rx2}
    - btn = rx4[2:0]
    - upd_valid=1, upd_ch=ch.
  - CH_GAP: all cs_n high, BYTE_GAP_CYC cycles. Then ch+1, or IDLE with busy←0 after ch N_CH-1.
- Timing:
  - Per-channel transaction cs_n-low length = CS_SETUP_CYC + 80*SCLK_DIV + 4*BYTE_GAP_CYC cycles.
  - Sweep length = N_CH*(that + 1 + BYTE_GAP_CYC) + 1.
- Channel isolation: other channels' outputs are untouched during a transaction. Only one cs_n is low at any time.

Decomposition:
- Package jstk_pkg:
  - JSTK_NBYTES=5, JSTK_CMD_LED=6'b100000.
  - Byte-index constants, FSM state enum.
  - Per-channel pack/unpack functions for pos and btn.
- Sub-module spi_byte_xfer:
  - Mode-0 single-byte shifter, parameter SCLK_DIV.
  - Ports: CLK, RST, start, tx_byte, MISO → SCLK, MOSI, rx_byte, done pulse.
  - The poller FSM sequences it.

Test Plan (sim params N_CH=2, SCLK_DIV=2, CS_SETUP_CYC=4, BYTE_GAP_CYC=3, POLL_DIV=2000; MISO model per channel):
- Single read: ch0 model returns 0xA5,0x02,0x3C,0x01,0x05; led_cmd=2'b10 → MOSI bytes 0x82,00,00,00,00; pos_x[9:0]=0x2A5, pos_y[9:0]=0x13C, btn[2:0]=3'b101; upd_valid pulse with upd_ch=0. Expected cs_n0-low length 4+160+12=176 cycles.
- Sweep order: ch1 returns 0xFF,0x03,0x00,0x00,0x02 → updates ch0 then ch1 (upd_ch 0 then 1); pos_x[19:10]=0x3FF, btn[5:3]=3'b010; cs_n never 2'b00; busy low after sweep.
- SPI timing: check SCLK idle low, MOSI stable across each SCLK rise, MISO sampled only at rises. A model driving MISO glitches during the high phase must not change results.
- Overrun: POLL_DIV=300 (< sweep length) → overrun=1 on second tick, sweep completes normally, overrun stays 1 until RST.
- poll_en=0 mid-sweep → current sweep finishes both channels, then no further cs_n activity; overrun stays 0.
- RST asserted mid-byte on ch1 → next cycle cs_n=2'b11, SCLK=0, all outputs 0, no upd_valid. After release, first sweep starts only at the next tick.
